// File: rtl/RSA_pkg.sv
// Shared RSA datapath types: key container width and the 2^P mod N controller state encoding.
package RSA_pkg;

  localparam int KEY_W = 1024;

  typedef logic [KEY_W-1:0] KeyType;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } TwoPowState_t;

endpackage

// File: rtl/rsa_two_power_mod.sv
// Serial shift-and-subtract generator of 2^POWER mod N (Montgomery R^2 constant),
// one modular doubling per cycle, valid/ready on both sides.
module rsa_two_power_mod
  import RSA_pkg::*;
#(
  parameter int MOD_WIDTH = 256,
  parameter int POWER     = 2 * MOD_WIDTH
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_valid,
  output logic   i_ready,
  input  KeyType i_modulus,
  output logic   o_valid,
  input  logic   o_ready,
  output KeyType o_out
);

  localparam int CNT_W = $clog2(POWER + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  typedef logic [MOD_WIDTH:0]   ext_t;
  typedef logic [MOD_WIDTH-1:0] mod_t;

  // r < N keeps 2r below 2^(MOD_WIDTH+1), so one conditional subtract is exact.
  function automatic mod_t mod_double(mod_t r, mod_t n);
    ext_t t;
    ext_t ne;
    ext_t d;
    t  = {r, 1'b0};
    ne = {1'b0, n};
    d  = t - ne;
    return (t >= ne) ? d[MOD_WIDTH-1:0] : t[MOD_WIDTH-1:0];
  endfunction

  logic [1:0]       state_q;
  mod_t             n_q;
  mod_t             r_q;
  logic [CNT_W-1:0] cnt_q;
  logic             degen_q;
  mod_t             out_q;

  mod_t r_next;
  logic last_round;
  mod_t mod_in;
  logic unused_mod;

  assign mod_in     = i_modulus[MOD_WIDTH-1:0];
  assign unused_mod = ^i_modulus;
  assign r_next     = mod_double(r_q, n_q);
  assign last_round = (cnt_q == CNT_W'(POWER - 1));

  assign i_ready = (state_q == ST_IDLE);
  assign o_valid = (state_q == ST_DONE);

  always_comb begin
    o_out = '0;
    o_out[MOD_WIDTH-1:0] = out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      degen_q <= 1'b0;
      out_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            n_q     <= mod_in;
            r_q     <= mod_t'(1);
            cnt_q   <= '0;
            // N of 0 or 1 still runs all rounds so latency stays fixed.
            degen_q <= ({1'b0, mod_in} < ext_t'(2));
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_q   <= r_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_round) begin
            out_q   <= degen_q ? '0 : r_next;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (o_ready) begin
            out_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_two_power_mod.sv
// Directed bench for rsa_two_power_mod: small (8-bit, P=16) and default-parameter instances.
module tb_rsa_two_power_mod;
  import RSA_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic   rst;
  logic   a_iv, a_ir, a_ov, a_or;
  KeyType a_mod, a_out;
  logic   b_iv, b_ir, b_ov, b_or;
  KeyType b_mod, b_out;

  rsa_two_power_mod #(.MOD_WIDTH(8), .POWER(16)) dut_a (
    .clk(clk), .rst(rst),
    .i_valid(a_iv), .i_ready(a_ir), .i_modulus(a_mod),
    .o_valid(a_ov), .o_ready(a_or), .o_out(a_out)
  );

  rsa_two_power_mod dut_b (
    .clk(clk), .rst(rst),
    .i_valid(b_iv), .i_ready(b_ir), .i_modulus(b_mod),
    .o_valid(b_ov), .o_ready(b_or), .o_out(b_out)
  );

  int vectors = 0;
  int miscompares = 0;
  longint unsigned exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: 2^p mod n by repeated doubling with a true remainder.
  function automatic longint unsigned model(input longint unsigned n, input int p);
    longint unsigned r;
    if (n < 2) return 0;
    r = 1;
    for (int i = 0; i < p; i++) r = (r * 2) % n;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for o_valid, compare against the scoreboard.
  task automatic run(input bit big, input int n, input string tag,
                     output int lat, output int acc);
    int p;
    int mw;
    KeyType got;
    longint unsigned e;
    p  = big ? 512 : 16;
    mw = big ? 256 : 8;
    if (big) begin
      check({tag, "_iready"}, 64'(b_ir), 64'd1);
      b_iv = 1'b1; b_mod = KeyType'(n);
    end else begin
      check({tag, "_iready"}, 64'(a_ir), 64'd1);
      a_iv = 1'b1; a_mod = KeyType'(n);
    end
    exp_q.push_back(model(longint'(n), p));
    tick();
    acc = cyc;
    lat = 1;
    a_iv = 1'b0;
    b_iv = 1'b0;
    while (!(big ? b_ov : a_ov) && lat < p + 50) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(p + 1));
    got = big ? b_out : a_out;
    e = exp_q.pop_front();
    check({tag, "_out"}, got[63:0], e);
    check({tag, "_upper_zero"}, 64'(|(got >> mw)), 64'd0);
  endtask

  int lat, acc1, acc2, acc3;
  KeyType held;

  initial begin
    rst = 1'b1;
    a_iv = 1'b0; a_or = 1'b0; a_mod = '0;
    b_iv = 1'b0; b_or = 1'b0; b_mod = '0;
    tick();
    tick();
    check("rst_a_iready", 64'(a_ir), 64'd1);
    check("rst_a_ovalid", 64'(a_ov), 64'd0);
    check("rst_a_out", 64'(|a_out), 64'd0);
    check("rst_b_iready", 64'(b_ir), 64'd1);
    check("rst_b_ovalid", 64'(b_ov), 64'd0);
    rst = 1'b0;
    tick();

    // Back-to-back with o_ready tied high.
    a_or = 1'b1;
    run(1'b0, 251, "n251", lat, acc1);
    check("n251_const", 64'(a_out), 64'd25);
    tick();
    run(1'b0, 255, "n255", lat, acc2);
    check("n255_const", 64'(a_out), 64'd1);
    tick();
    run(1'b0, 13, "n13", lat, acc3);
    check("n13_const", 64'(a_out), 64'd3);
    check("issue_interval_1", 64'(acc2 - acc1), 64'd18);
    check("issue_interval_2", 64'(acc3 - acc2), 64'd18);
    tick();

    // Degenerate moduli.
    run(1'b0, 0, "n0", lat, acc1);
    tick();
    run(1'b0, 1, "n1", lat, acc1);
    tick();

    // Backpressure: hold o_ready low in DONE, wiggle the request side.
    a_or = 1'b0;
    run(1'b0, 251, "bp", lat, acc1);
    held = a_out;
    for (int i = 0; i < 5; i++) begin
      a_iv = ~a_iv;
      a_mod = KeyType'($urandom_range(0, 255));
      tick();
      check("bp_ovalid", 64'(a_ov), 64'd1);
      check("bp_out_stable", a_out[63:0], held[63:0]);
      check("bp_iready", 64'(a_ir), 64'd0);
    end
    a_iv = 1'b0;
    a_or = 1'b1;
    tick();
    check("bp_release_ovalid", 64'(a_ov), 64'd0);
    check("bp_release_iready", 64'(a_ir), 64'd1);
    for (int i = 0; i < 20; i++) tick();
    check("no_queued_request", 64'(a_ov), 64'd0);

    // Reset during the fifth CALC cycle aborts the job.
    a_iv = 1'b1; a_mod = KeyType'(251);
    tick();
    a_iv = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    check("abort_iready", 64'(a_ir), 64'd1);
    check("abort_ovalid", 64'(a_ov), 64'd0);
    check("abort_out", 64'(|a_out), 64'd0);
    rst = 1'b0;
    run(1'b0, 13, "after_abort", lat, acc1);
    tick();

    // Default parameters: 256-bit modulus, POWER = 512.
    b_or = 1'b1;
    run(1'b1, 13, "default_n13", lat, acc1);
    check("default_n13_const", b_out[63:0], 64'd9);
    tick();
    check("default_release", 64'(b_ov), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
